// File: rtl/add_arbiter.sv
// ============================================================================
// add_arbiter
// ----------------------------------------------------------------------------
// Shares one external combinational adder among NUM_REQ requesters. A winner
// is picked in IDLE, its operands are captured and driven to the adder for
// exactly one cycle (OPER), and the registered sum is returned with the
// requester ID over a valid/ready response channel (RESP).
//
// Build option:
//   ADD_ARB_FIXED_PRIO_EN - when defined, the lowest-index asserted request
//                           always wins and no rotation pointer exists.
//                           When undefined, arbitration is round-robin.
//
// Ports:
//   clk        in   1            system clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   req        in   NUM_REQ      per-requester request
//   a_flat     in   NUM_REQ*W    operand A, requester i at [i*W +: W]
//   b_flat     in   NUM_REQ*W    operand B, requester i at [i*W +: W]
//   gnt        out  NUM_REQ      one-hot single-cycle accept pulse
//   add_a      out  W            operand A to shared adder
//   add_b      out  W            operand B to shared adder
//   add_sum    in   W+1          combinational sum from shared adder
//   rsp_valid  out  1            response valid
//   rsp_ready  in   1            response consumer ready
//   rsp_id     out  IDW          requester whose sum is presented
//   rsp_sum    out  W+1          registered sum
// ============================================================================
module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] a_flat,
    input  logic [NUM_REQ*W-1:0] b_flat,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W:0]           add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]         op_a_q, op_a_d;
    logic [W-1:0]         op_b_q, op_b_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [W:0]           rsp_sum_q, rsp_sum_d;
`ifndef ADD_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]       ptr_q, ptr_d;
`endif

    // Unpack the flat operand buses into per-requester arrays.
    logic [W-1:0] a_arr [NUM_REQ];
    logic [W-1:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_flat[gi*W +: W];
            assign b_arr[gi] = b_flat[gi*W +: W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic           win_found;
    logic [IDW-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef ADD_ARB_FIXED_PRIO_EN
        // Scan downward so the last hit (lowest index) wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
`else
        // Scan offsets from farthest to nearest so the last hit is the first
        // set request above ptr_q, wrapping modulo NUM_REQ.
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[(int'(ptr_q) + off) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(ptr_q) + off) % NUM_REQ);
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
`ifndef ADD_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_a_d         = a_arr[win_idx];
                    op_b_d         = b_arr[win_idx];
                    id_d           = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
`ifndef ADD_ARB_FIXED_PRIO_EN
                    ptr_d          = win_idx;
`endif
                    state_d        = OPER;
                end
            end
            OPER: begin
                // The shared adder sees op_a_q/op_b_q this cycle only.
                rsp_sum_d   = add_sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                gnt_d       = '0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

`ifndef ADD_ARB_FIXED_PRIO_EN
    // Starting at NUM_REQ-1 makes requester 0 the first winner after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Adder operands come straight from the capture registers, so they hold
    // their last values outside OPER.
    assign gnt       = gnt_q;
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = 4;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ*W-1:0] a_flat = '0;
    logic [NUM_REQ*W-1:0] b_flat = '0;
    logic [NUM_REQ-1:0]   gnt;
    logic [W-1:0]         add_a;
    logic [W-1:0]         add_b;
    logic [W:0]           add_sum;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic [W:0]           rsp_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Model of the shared adder the arbiter feeds.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    add_arbiter #(.NUM_REQ(NUM_REQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_id;
        logic [4:0]  exp_sum;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] pk(input logic [3:0] x0, input logic [3:0] x1,
                                       input logic [3:0] x2, input logic [3:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for a grant pulse, sampling on falling edges.
    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == '0 && cyc < 10);
        if (gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout actual=0 required=nonzero");
        end
    endtask

    // Protocol monitor: gnt one-hot/zero, response held under backpressure.
    logic       hold = 1'b0;
    logic [1:0] h_id;
    logic [4:0] h_sum;

    always @(posedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL gnt_onehot actual=%b required=onehot0", gnt);
            end
            if (hold) begin
                checks++;
                if (!rsp_valid || rsp_id !== h_id || rsp_sum !== h_sum) begin
                    errors++;
                    $display("FAIL rsp_stable actual=v%0d/id%0d/s%0d required=v1/id%0d/s%0d",
                             rsp_valid, rsp_id, rsp_sum, h_id, h_sum);
                end
            end
            hold  = rsp_valid && !rsp_ready;
            h_id  = rsp_id;
            h_sum = rsp_sum;
        end
    end

    initial begin
        int cyc;
        int rr_id [5];
        logic [4:0] rr_sum [5];

        // ---------------- stimulus table ----------------
        vecs[0] = '{4'b0001, pk(4,0,0,0),  pk(4,0,0,0),  4'b0001, 2'd0, 5'd8};
        vecs[1] = '{4'b0001, pk(5,0,0,0),  pk(6,0,0,0),  4'b0001, 2'd0, 5'd11};
        vecs[2] = '{4'b0100, pk(0,0,15,0), pk(0,0,15,0), 4'b0100, 2'd2, 5'd30};
        vecs[3] = '{4'b1000, pk(0,0,0,9),  pk(0,0,0,1),  4'b1000, 2'd3, 5'd10};
`ifdef ADD_ARB_FIXED_PRIO_EN
        rr_id  = '{0, 0, 0, 0, 0};
        rr_sum = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4};
`else
        rr_id  = '{0, 1, 2, 3, 0};
        rr_sum = '{5'd4, 5'd7, 5'd10, 5'd13, 5'd4};
`endif
        for (int i = 0; i < 5; i++) begin
            vecs[4+i] = '{4'b1111, pk(1,2,3,4), pk(3,5,7,9),
                          4'(1 << rr_id[i]), 2'(rr_id[i]), rr_sum[i]};
        end
        vecs[9]  = '{4'b1000, pk(0,0,0,2), pk(0,0,0,3), 4'b1000, 2'd3, 5'd5};
        vecs[10] = '{4'b1001, pk(6,0,0,2), pk(1,0,0,3), 4'b0001, 2'd0, 5'd7};
`ifdef ADD_ARB_FIXED_PRIO_EN
        vecs[11] = '{4'b1001, pk(6,0,0,2), pk(1,0,0,3), 4'b0001, 2'd0, 5'd7};
`else
        vecs[11] = '{4'b1001, pk(6,0,0,2), pk(1,0,0,3), 4'b1000, 2'd3, 5'd5};
`endif

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 12; i++) begin
            req    = vecs[i].req;
            a_flat = vecs[i].a;
            b_flat = vecs[i].b;
            wait_gnt(cyc);
            chk($sformatf("v%0d_gnt", i), gnt, vecs[i].exp_gnt);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_id", i), rsp_id, vecs[i].exp_id);
            chk($sformatf("v%0d_sum", i), rsp_sum, vecs[i].exp_sum);
            chk($sformatf("v%0d_gnt_pulse", i), gnt, 0);
            $display("txn v%0d req=%b id=%0d sum=%0d", i, vecs[i].req, rsp_id, rsp_sum);
        end
        req = '0;
        @(negedge clk);

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        req    = 4'b0010;
        a_flat = pk(0,3,0,0);
        b_flat = pk(0,4,0,0);
        wait_gnt(cyc);
        chk("bp_gnt", gnt, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
            chk($sformatf("bp%0d_id", k), rsp_id, 1);
            chk($sformatf("bp%0d_sum", k), rsp_sum, 7);
            chk($sformatf("bp%0d_nognt", k), gnt, 0);
        end
        $display("txn bp held id=%0d sum=%0d", rsp_id, rsp_sum);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", rsp_valid, 0);
        chk("bp_done_nognt", gnt, 0);
        @(negedge clk);
        chk("bp_regrant", gnt, 4'b0010);
        @(negedge clk);
        chk("bp_re_sum", rsp_sum, 7);
        $display("txn bp regrant id=%0d sum=%0d", rsp_id, rsp_sum);
        req = '0;
        @(negedge clk);

        // ---------------- reset during OPER (requester 1) ----------------
        req    = 4'b0010;
        a_flat = pk(0,7,0,0);
        b_flat = pk(0,2,0,0);
        wait_gnt(cyc);
        chk("lat_gnt_cycles", cyc, 1);
        chk("mr_gnt", gnt, 4'b0010);
        chk("mr_add_a", add_a, 7);
        chk("mr_add_b", add_b, 2);
        rst_n = 1'b0;
        #1;
        chk("mr_async_gnt", gnt, 0);
        chk("mr_async_valid", rsp_valid, 0);
        chk("mr_async_add_a", add_a, 0);
        chk("mr_async_sum", rsp_sum, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        req    = 4'b0011;
        a_flat = pk(1,7,0,0);
        b_flat = pk(1,2,0,0);
        wait_gnt(cyc);
        chk("mr_after_gnt", gnt, 4'b0001);
        @(negedge clk);
        chk("mr_after_sum", rsp_sum, 2);
        $display("txn mr1 id=%0d sum=%0d", rsp_id, rsp_sum);
        req = '0;
        @(negedge clk);

        // ---------------- reset during OPER (requester 0): pointer restore ----------------
        req    = 4'b0001;
        a_flat = pk(3,0,0,0);
        b_flat = pk(3,0,0,0);
        wait_gnt(cyc);
        chk("mr0_gnt", gnt, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mr0_async_gnt", gnt, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        req    = 4'b0011;
        a_flat = pk(2,5,0,0);
        b_flat = pk(2,5,0,0);
        wait_gnt(cyc);
        chk("mr0_after_gnt", gnt, 4'b0001);
        @(negedge clk);
        chk("mr0_after_id", rsp_id, 0);
        chk("mr0_after_sum", rsp_sum, 4);
        $display("txn mr0 id=%0d sum=%0d", rsp_id, rsp_sum);
        req = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
